// File: rtl/dmem_sized_if.sv
// Request/response bus of the sized data memory: one load or store per cycle,
// registered writeback result one cycle later.
interface dmem_sized_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              req_memtoreg;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_result;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_memtoreg, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_result, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_memtoreg, req_addr, req_wdata,
    output req_ready, resp_valid, resp_result, resp_err
  );
endinterface

// File: rtl/dmem_sized.sv
// Byte-lane writable data memory with sized/extended loads and error detection.
// Optional zero-clear of the array after reset: define DMEM_CLEAR_ON_RESET_EN.
module dmem_sized #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_sized_if.slave   bus
);
  localparam int unsigned IdxW = $clog2(DEPTH);

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic [0:0] {StClear, StRun} state_e;
  logic [IdxW-1:0] clr_q, clr_d;
`else
  typedef enum logic [0:0] {StIdle, StRun} state_e;
`endif

  state_e state_q, state_d;

  logic [31:0]     mem [DEPTH];
  logic [IdxW-1:0] idx;
  logic [1:0]      off;
  logic            accept, err, oor;
  logic [3:0]      be;
  logic [31:0]     wdata_rep, rd_word, ld_data, addr32;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [IdxW-1:0] wr_idx;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;
  logic            resp_valid_q, resp_err_q;
  logic [31:0]     resp_result_q;

  assign bus.req_ready   = (state_q == StRun);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_err    = resp_err_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign idx    = bus.req_addr[IdxW+1:2];
  assign off    = bus.req_addr[1:0];
  // Any address bit above the word index means the access is past the array.
  assign oor    = (bus.req_addr >> (IdxW + 2)) != '0;

  if (ADDR_W >= 32) begin : g_addr_trunc
    assign addr32 = bus.req_addr[31:0];
  end else begin : g_addr_ext
    assign addr32 = {{(32 - ADDR_W){1'b0}}, bus.req_addr};
  end

  always_comb begin
    err       = oor;
    be        = 4'b0000;
    wdata_rep = bus.req_wdata;
    case (bus.req_size)
      2'd0: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
        err       = oor || off[0];
      end
      2'd2: begin
        be  = 4'b1111;
        err = oor || (off != 2'd0);
      end
      default: err = 1'b1;
    endcase
  end

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[8*off +: 8];
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (bus.req_size)
      2'd0:    ld_data = bus.req_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'd1:    ld_data = bus.req_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  // Single write port shared between the clear sweep and stores.
  always_comb begin
    wr_idx  = idx;
    wr_be   = (accept && bus.req_write && !err) ? be : 4'b0000;
    wr_data = wdata_rep;
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (state_q == StClear) begin
      wr_idx  = clr_q;
      wr_be   = 4'b1111;
      wr_data = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef DMEM_CLEAR_ON_RESET_EN
    clr_d   = clr_q;
    case (state_q)
      StClear: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == IdxW'(DEPTH - 1)) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
`else
    case (state_q)
      StIdle:  state_d = StRun;
      default: state_d = StRun;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      state_q <= StClear;
      clr_q   <= '0;
`else
      state_q <= StIdle;
`endif
    end else begin
      state_q <= state_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_result_q <= '0;
    end else begin
      resp_valid_q <= accept;
      if (accept) begin
        resp_err_q <= err;
        if (err)                                       resp_result_q <= '0;
        else if (!bus.req_write && bus.req_memtoreg)   resp_result_q <= ld_data;
        else                                           resp_result_q <= addr32;
      end
    end
  end
endmodule
